wbu_commit: RTL and testbench

- Parametrised writeback/commit stage for the single-issue multi-cycle core.
- Sits between EXU and IFU. Accepts one executed instruction over a valid/ready handshake, then:
  - commits the GPR write,
  - performs the CSR/trap side effects,
  - updates the architectural PC,
  - offers the new PC to IFU over a second valid/ready handshake.
- Owns the GPR file, a generalised machine CSR set and the PC register. Exposes two combinational GPR read ports to IDU/EXU.

---
 rtl/wbu_pkg.sv | 46 ++++
 rtl/wbu_csr_file.sv | 104 ++++++++++
 rtl/wbu_commit.sv | 123 ++++++++++++
 tb/tb_wbu_commit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wbu_pkg.sv
// Shared types and constants for the writeback/commit stage: CSR opcodes,
// CSR addresses and FSM states.
package wbu_pkg;

  typedef enum logic [2:0] {
    CSR_NONE  = 3'd0,
    CSR_ECALL = 3'd1,
    CSR_CSRRW = 3'd2,
    CSR_CSRRS = 3'd3,
    CSR_MRET  = 3'd4,
    CSR_CSRRC = 3'd5
  } csr_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } wbu_state_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MCAUSE_ECALL_M = 11;

  // Encodings 6 and 7 are reserved and behave as "no CSR operation".
  function automatic csr_op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'd1:    return CSR_ECALL;
      3'd2:    return CSR_CSRRW;
      3'd3:    return CSR_CSRRS;
      3'd4:    return CSR_MRET;
      3'd5:    return CSR_CSRRC;
      default: return CSR_NONE;
    endcase
  endfunction

  function automatic logic is_csr_access(input csr_op_e op);
    return (op == CSR_CSRRW) || (op == CSR_CSRRS) || (op == CSR_CSRRC);
  endfunction

endpackage

// File: rtl/wbu_csr_file.sv
// Machine CSR storage, address decode, read-modify-write and trap updates.
// Optional mcycle/minstret counters are enabled with WBU_COUNTERS_EN.
module wbu_csr_file
  import wbu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_commit,
  input  logic [2:0]      i_op,
  input  logic [11:0]     i_addr,
  input  logic [XLEN-1:0] i_src,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_access,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc
);

  logic [XLEN-1:0] r_mstatus, r_mtvec, r_mepc, r_mcause;
  csr_op_e         w_op;
  logic            w_mapped, w_writable;
  logic [XLEN-1:0] w_rdata, w_new;

`ifdef WBU_COUNTERS_EN
  logic [63:0] r_mcycle, r_minstret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
      if (i_commit) r_minstret <= r_minstret + 64'd1;
    end
  end
`endif

  function automatic logic [XLEN-1:0] csr_rmw(input csr_op_e op,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] mask);
    case (op)
      CSR_CSRRW: return mask;
      CSR_CSRRS: return old | mask;
      CSR_CSRRC: return old & ~mask;
      default:   return old;
    endcase
  endfunction

  always_comb begin
    w_rdata    = '0;
    w_mapped   = 1'b1;
    w_writable = 1'b0;
    case (i_addr)
      CSR_MSTATUS: begin w_rdata = r_mstatus; w_writable = 1'b1; end
      CSR_MTVEC:   begin w_rdata = r_mtvec;   w_writable = 1'b1; end
      CSR_MEPC:    begin w_rdata = r_mepc;    w_writable = 1'b1; end
      CSR_MCAUSE:  begin w_rdata = r_mcause;  w_writable = 1'b1; end
`ifdef WBU_COUNTERS_EN
      // Counters are read-only: mapped (no illegal) but never writable.
      CSR_MCYCLE:    w_rdata = XLEN'(r_mcycle[31:0]);
      CSR_MINSTRET:  w_rdata = XLEN'(r_minstret[31:0]);
      CSR_MCYCLEH:   w_rdata = XLEN'(r_mcycle[63:32]);
      CSR_MINSTRETH: w_rdata = XLEN'(r_minstret[63:32]);
`endif
      default: w_mapped = 1'b0;
    endcase
  end

  assign w_op      = decode_op(i_op);
  assign w_new     = csr_rmw(w_op, w_rdata, i_src);
  assign o_access  = is_csr_access(w_op);
  assign o_illegal = o_access & ~w_mapped;
  assign o_rdata   = w_rdata;
  assign o_mtvec   = r_mtvec;
  assign o_mepc    = r_mepc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus <= MSTATUS_RST;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else if (i_commit) begin
      if (o_access && w_writable) begin
        case (i_addr)
          CSR_MSTATUS: r_mstatus <= w_new;
          CSR_MTVEC:   r_mtvec   <= w_new;
          CSR_MEPC:    r_mepc    <= w_new;
          CSR_MCAUSE:  r_mcause  <= w_new;
          default: ;
        endcase
      end
      if (w_op == CSR_ECALL) begin
        r_mepc   <= i_pc;
        r_mcause <= XLEN'(MCAUSE_ECALL_M);
      end
    end
  end

endmodule

// File: rtl/wbu_commit.sv
// Writeback/commit stage: GPR file, PC register and accept/offer FSM.
// Optional counters (WBU_COUNTERS_EN) live in wbu_csr_file.
module wbu_commit
  import wbu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NREGS       = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h2000_0000),
  parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_next_pc,
  input  logic            in_wen,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [2:0]      in_csr_op,
  input  logic [11:0]     in_csr_addr,
  input  logic [XLEN-1:0] in_csr_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  localparam int RAW = $clog2(NREGS);

  wbu_state_e      r_state;
  logic            r_in_ready, r_out_valid, r_illegal;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_gpr [NREGS];

  csr_op_e         w_op;
  logic            w_accept, w_gpr_we, w_csr_access, w_csr_illegal;
  logic [XLEN-1:0] w_csr_rdata, w_mtvec, w_mepc, w_next_pc, w_wb_data;

  // x0 and addresses beyond the implemented file are hardwired to zero.
  function automatic logic reg_ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREGS);
  endfunction

  assign rs1_data = reg_ok(rs1_addr) ? r_gpr[rs1_addr[RAW-1:0]] : '0;
  assign rs2_data = reg_ok(rs2_addr) ? r_gpr[rs2_addr[RAW-1:0]] : '0;

  assign w_op     = decode_op(in_csr_op);
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  wbu_csr_file #(.XLEN(XLEN), .MSTATUS_RST(MSTATUS_RST)) u_csr (
    .clk       (clk),
    .rst       (rst),
    .i_commit  (w_accept),
    .i_op      (in_csr_op),
    .i_addr    (in_csr_addr),
    .i_src     (in_csr_src),
    .i_pc      (in_pc),
    .o_rdata   (w_csr_rdata),
    .o_access  (w_csr_access),
    .o_illegal (w_csr_illegal),
    .o_mtvec   (w_mtvec),
    .o_mepc    (w_mepc)
  );

  // CSR instructions return the old CSR value to rd, overriding in_wdata/in_wen.
  assign w_wb_data = w_csr_access ? w_csr_rdata : in_wdata;
  assign w_gpr_we  = w_accept && reg_ok(in_rd) && (w_csr_access || in_wen);

  always_comb begin
    w_next_pc = in_next_pc;
    case (w_op)
      CSR_ECALL: w_next_pc = w_mtvec;
      CSR_MRET:  w_next_pc = w_mepc;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
    end else if (w_gpr_we) begin
      r_gpr[in_rd[RAW-1:0]] <= w_wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_pc        <= RESET_PC;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_state     <= ST_DONE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b1;
          r_illegal   <= w_csr_illegal;
          r_pc        <= w_next_pc;
        end
        ST_DONE: if (out_ready) begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_pc;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_wbu_commit.sv
// Directed scoreboard bench for wbu_commit in the RV32E (NREGS=16) configuration.
module tb_wbu_commit;
  import wbu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen, out_valid, out_ready, out_illegal;
  logic [31:0] in_pc, in_next_pc, in_wdata, in_csr_src, out_pc, rs1_data, rs2_data;
  logic [4:0]  in_rd, rs1_addr, rs2_addr;
  logic [2:0]  in_csr_op;
  logic [11:0] in_csr_addr;

  int checks = 0;
  int errors = 0;
  int n_commit = 0;
  logic [31:0] q_pc[$];
  logic        q_ill[$];

  always #5 clk = ~clk;

  wbu_commit #(.XLEN(32), .NREGS(16), .RESET_PC(32'h2000_0000),
               .MSTATUS_RST(32'h0000_1800)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_next_pc(in_next_pc), .in_wen(in_wen), .in_rd(in_rd),
    .in_wdata(in_wdata), .in_csr_op(in_csr_op), .in_csr_addr(in_csr_addr),
    .in_csr_src(in_csr_src), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_illegal(out_illegal), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] npc, input logic wen,
                       input logic [4:0] rd, input logic [31:0] wd, input logic [2:0] op,
                       input logic [11:0] addr, input logic [31:0] src);
    in_pc = pc; in_next_pc = npc; in_wen = wen; in_rd = rd; in_wdata = wd;
    in_csr_op = op; in_csr_addr = addr; in_csr_src = src; in_valid = 1'b1;
  endtask

  task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    rs1_addr = a;
    rs2_addr = a;
    #1;
    chk(tag, rs1_data, exp);
    chk(tag, rs2_data, exp);
  endtask

  // Bounded wait for the PC offer, then pop the scoreboard entry.
  task automatic wait_out();
    int n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_latency", n, 0);
    if (q_pc.size() > 0) begin
      chk("out_pc", out_pc, q_pc.pop_front());
      chk("out_illegal", out_illegal, q_ill.pop_front());
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] npc, input logic wen,
                       input logic [4:0] rd, input logic [31:0] wd, input logic [2:0] op,
                       input logic [11:0] addr, input logic [31:0] src,
                       input logic [31:0] exp_pc, input logic exp_ill);
    @(negedge clk);
    drive(pc, npc, wen, rd, wd, op, addr, src);
    q_pc.push_back(exp_pc);
    q_ill.push_back(exp_ill);
    chk("in_ready_pre", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_commit++;
    wait_out();
    @(posedge clk); #1;
    chk("illegal_clear", out_illegal, 1'b0);
    chk("back_idle", in_ready, 1'b1);
  endtask

  initial begin
    int c;
    rst = 1'b1; out_ready = 1'b1; rs1_addr = '0; rs2_addr = '0;
    drive('0, '0, 1'b0, '0, '0, 3'd0, '0, '0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_pc", out_pc, 32'h2000_0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_illegal", out_illegal, 1'b0);
    for (int r = 1; r < 32; r++) rdchk("rst_gpr", 5'(r), 32'h0);

    issue(32'h2000_0000, 32'h2000_0004, 0, 5'd1, 0, 3'd3, 12'h300, 0, 32'h2000_0004, 0);
    rdchk("mstatus_rst", 5'd1, 32'h1800);
    issue(32'h2000_0004, 32'h2000_0008, 1, 5'd5, 32'h55, 3'd0, 0, 0, 32'h2000_0008, 0);
    rdchk("x5_write", 5'd5, 32'h55);
    issue(32'h2000_0008, 32'h2000_000c, 1, 5'd0, 32'hdead, 3'd0, 0, 0, 32'h2000_000c, 0);
    rdchk("x0_zero", 5'd0, 32'h0);
    issue(32'h2000_000c, 32'h2000_0010, 1, 5'd20, 32'hbeef, 3'd0, 0, 0, 32'h2000_0010, 0);
    rdchk("x20_zero", 5'd20, 32'h0);
    rdchk("x4_alias", 5'd4, 32'h0);

    issue(32'h2000_0010, 32'h2000_0014, 1, 5'd6, 32'hffff, 3'd2, 12'h305, 32'h2000_0100,
          32'h2000_0014, 0);
    rdchk("x6_old_mtvec", 5'd6, 32'h0);
    issue(32'h2000_0040, 32'h2000_0044, 0, 5'd0, 0, 3'd1, 0, 0, 32'h2000_0100, 0);
    issue(32'h2000_0100, 32'h2000_0104, 0, 5'd7, 0, 3'd3, 12'h341, 0, 32'h2000_0104, 0);
    rdchk("mepc", 5'd7, 32'h2000_0040);
    issue(32'h2000_0104, 32'h2000_0108, 0, 5'd8, 0, 3'd3, 12'h342, 0, 32'h2000_0108, 0);
    rdchk("mcause", 5'd8, 32'd11);
    issue(32'h2000_0108, 32'h2000_010c, 0, 5'd0, 0, 3'd4, 0, 0, 32'h2000_0040, 0);
    issue(32'h2000_0040, 32'h2000_0044, 0, 5'd9, 0, 3'd3, 12'h300, 0, 32'h2000_0044, 0);
    rdchk("mstatus_after_mret", 5'd9, 32'h1800);

    issue(32'h2000_0044, 32'h2000_0048, 0, 5'd10, 0, 3'd5, 12'h300, 32'h800, 32'h2000_0048, 0);
    rdchk("csrrc_old", 5'd10, 32'h1800);
    issue(32'h2000_0048, 32'h2000_004c, 0, 5'd11, 0, 3'd3, 12'h300, 0, 32'h2000_004c, 0);
    rdchk("csrrc_new", 5'd11, 32'h1000);
    issue(32'h2000_004c, 32'h2000_0050, 0, 5'd12, 0, 3'd3, 12'h305, 32'h3, 32'h2000_0050, 0);
    rdchk("csrrs_old", 5'd12, 32'h2000_0100);
    issue(32'h2000_0050, 32'h2000_0054, 0, 5'd13, 0, 3'd3, 12'h305, 0, 32'h2000_0054, 0);
    rdchk("csrrs_new", 5'd13, 32'h2000_0103);

    // Backpressure: second request held on in_valid must not be taken.
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h2000_0300, 32'h2000_0304, 1, 5'd14, 32'h77, 3'd0, 0, 0);
    q_pc.push_back(32'h2000_0304);
    q_ill.push_back(1'b0);
    @(posedge clk); #1;
    n_commit++;
    drive(32'h2000_0304, 32'h2000_0999, 1, 5'd15, 32'h99, 3'd0, 0, 0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_pc", out_pc, 32'h2000_0304);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", in_ready, 1'b1);
    chk("bp_release_valid", out_valid, 1'b0);
    rdchk("bp_x14", 5'd14, 32'h77);
    rdchk("bp_x15", 5'd15, 32'h0);

    issue(32'h2000_0304, 32'h2000_0308, 1, 5'd3, 32'h1234, 3'd2, 12'h7C0, 32'hffff,
          32'h2000_0308, 1);
    rdchk("illegal_rd", 5'd3, 32'h0);
    issue(32'h2000_0308, 32'h2000_030c, 1, 5'd2, 32'h42, 3'd6, 12'h300, 32'hffff_ffff,
          32'h2000_030c, 0);
    rdchk("op6_wdata", 5'd2, 32'h42);
    issue(32'h2000_030c, 32'h2000_0310, 0, 5'd1, 0, 3'd3, 12'h300, 0, 32'h2000_0310, 0);
    rdchk("op6_no_csr", 5'd1, 32'h1000);

    // Reset during an offered request discards it.
    @(negedge clk);
    drive(32'h2000_0310, 32'h2000_0314, 1, 5'd1, 32'haaaa, 3'd2, 12'h305, 32'h5);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_commit = 0;
    chk("rst2_pc", out_pc, 32'h2000_0000);
    chk("rst2_in_ready", in_ready, 1'b1);
    chk("rst2_out_valid", out_valid, 1'b0);
    rdchk("rst2_x1", 5'd1, 32'h0);
    rdchk("rst2_x5", 5'd5, 32'h0);

    issue(32'h2000_0000, 32'h2000_0004, 0, 5'd1, 0, 3'd3, 12'h305, 0, 32'h2000_0004, 0);
    rdchk("rst2_mtvec", 5'd1, 32'h0);
    issue(32'h2000_0004, 32'h2000_0008, 1, 5'd5, 32'h1, 3'd0, 0, 0, 32'h2000_0008, 0);
    issue(32'h2000_0008, 32'h2000_000c, 0, 5'd9, 0, 3'd3, 12'h300, 0, 32'h2000_000c, 0);
    rdchk("rst2_mstatus", 5'd9, 32'h1800);

    c = n_commit;
`ifdef WBU_COUNTERS_EN
    issue(32'h2000_000c, 32'h2000_0010, 0, 5'd12, 0, 3'd3, 12'hB02, 32'hff, 32'h2000_0010, 0);
    rdchk("minstret", 5'd12, 32'(c));
    issue(32'h2000_0010, 32'h2000_0014, 0, 5'd13, 0, 3'd3, 12'hB82, 0, 32'h2000_0014, 0);
    rdchk("minstreth", 5'd13, 32'h0);
`else
    issue(32'h2000_000c, 32'h2000_0010, 1, 5'd12, 32'h77, 3'd3, 12'hB02, 32'hff,
          32'h2000_0010, 1);
    rdchk("minstret_unmapped", 5'd12, 32'h0);
    chk("commit_count", n_commit, c + 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
